// File: rtl/pattern_round_ctrl_if.sv
// Bus between the round sequencer and its neighbours: pattern generator,
// display driver and key debouncer. The master modport is the controller side.
interface pattern_round_ctrl_if #(
    parameter int NUM_SYM = 9
);
    logic                   start;
    logic [2*NUM_SYM-1:0]   pattern;
    logic                   pattern_valid;
    logic                   show_valid;
    logic [1:0]             show_sym;
    logic [3:0]             show_idx;
    logic                   in_valid;
    logic [1:0]             in_sym;
    logic                   await_input;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [3:0]             score;
    logic                   timed_out;

    modport master (
        input  start, pattern, pattern_valid, in_valid, in_sym,
        output show_valid, show_sym, show_idx, await_input,
               busy, done, pass, score, timed_out
    );

    modport slave (
        output start, pattern, pattern_valid, in_valid, in_sym,
        input  show_valid, show_sym, show_idx, await_input,
               busy, done, pass, score, timed_out
    );
endinterface

// File: rtl/pattern_round_ctrl.sv
// Memory-game round sequencer: latch pattern, play it, then check presses.
// Define TIMEOUT_EN to end the input phase after TIMEOUT_CYCLES idle cycles.
module pattern_round_ctrl #(
    parameter int NUM_SYM        = 9,
    parameter int SHOW_CYCLES    = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pattern_round_ctrl_if.master bus
);
    localparam int PW       = 2 * NUM_SYM;
    localparam int MAX_SG   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC  = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int TW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_SYM - 1);

    typedef enum logic [2:0] {IDLE, WAIT_PAT, SHOW, GAP, INPUT, RESULT} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pat_q, pat_n;
    logic [3:0]      idx, idx_n;
    logic [TW-1:0]   timer, timer_n;
    logic [3:0]      score_q, score_n;
    logic            pass_q, pass_n;
    logic            timed_q, timed_n;
    logic [1:0]      show_sym_q;
    logic            show_valid_q, await_q, busy_q, done_q;

    function automatic logic [1:0] sym_at(input logic [PW-1:0] p, input logic [3:0] i);
        return p[{i, 1'b0} +: 2];
    endfunction

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        idx_n   = idx;
        timer_n = timer;
        score_n = score_q;
        pass_n  = pass_q;
        timed_n = timed_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = WAIT_PAT;
                    pass_n  = 1'b0;
                    score_n = '0;
                    timed_n = 1'b0;
                end
            end
            WAIT_PAT: begin
                if (bus.pattern_valid) begin
                    pat_n   = bus.pattern;
                    idx_n   = '0;
                    timer_n = '0;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (timer == TW'(SHOW_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = GAP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = INPUT;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = SHOW;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            INPUT: begin
                // A press always wins over a timer expiring in the same cycle.
                if (bus.in_valid) begin
                    timer_n = '0;
                    if (bus.in_sym != 2'd3 && bus.in_sym == sym_at(pat_q, idx)) begin
                        score_n = score_q + 4'd1;
                        if (idx == LAST_IDX) begin
                            pass_n  = 1'b1;
                            state_n = RESULT;
                        end else begin
                            idx_n = idx + 4'd1;
                        end
                    end else begin
                        pass_n  = 1'b0;
                        state_n = RESULT;
                    end
                end
`ifdef TIMEOUT_EN
                else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    pass_n  = 1'b0;
                    timed_n = 1'b1;
                    state_n = RESULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
            end
            RESULT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pat_q        <= '0;
            idx          <= '0;
            timer        <= '0;
            score_q      <= '0;
            pass_q       <= 1'b0;
            timed_q      <= 1'b0;
            show_sym_q   <= '0;
            show_valid_q <= 1'b0;
            await_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_n;
            pat_q        <= pat_n;
            idx          <= idx_n;
            timer        <= timer_n;
            score_q      <= score_n;
            pass_q       <= pass_n;
            timed_q      <= timed_n;
            show_valid_q <= (state_n == SHOW);
            await_q      <= (state_n == INPUT);
            busy_q       <= (state_n != IDLE);
            done_q       <= (state_n == RESULT);
            if (state_n == SHOW) begin
                show_sym_q <= sym_at(pat_n, idx_n);
            end
        end
    end

    assign bus.show_valid  = show_valid_q;
    assign bus.show_sym    = show_sym_q;
    assign bus.show_idx    = idx;
    assign bus.await_input = await_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.score       = score_q;
    assign bus.timed_out   = timed_q;
endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Bench for pattern_round_ctrl: directed rounds plus random patterns/presses
// checked against a round-level model. Timeout rounds run when TIMEOUT_EN is defined.
module tb_pattern_round_ctrl;
    localparam int NUM_SYM        = 9;
    localparam int SHOW_CYCLES    = 2;
    localparam int GAP_CYCLES     = 1;
    localparam int TIMEOUT_CYCLES = 5;
    localparam int SYM_PERIOD     = SHOW_CYCLES + GAP_CYCLES;
    localparam int PLAY_LEN       = NUM_SYM * SYM_PERIOD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vectors = 0;
    int   n_miscompares = 0;

    logic [1:0]           sym   [NUM_SYM];
    logic [1:0]           press [NUM_SYM];
    logic [2*NUM_SYM-1:0] pat;

    pattern_round_ctrl_if #(.NUM_SYM(NUM_SYM)) bus ();

    pattern_round_ctrl #(
        .NUM_SYM        (NUM_SYM),
        .SHOW_CYCLES    (SHOW_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_show_valid"},  32'(bus.show_valid),  32'd0);
        check_output({tag, "_show_sym"},    32'(bus.show_sym),    32'd0);
        check_output({tag, "_show_idx"},    32'(bus.show_idx),    32'd0);
        check_output({tag, "_await_input"}, 32'(bus.await_input), 32'd0);
        check_output({tag, "_busy"},        32'(bus.busy),        32'd0);
        check_output({tag, "_done"},        32'(bus.done),        32'd0);
        check_output({tag, "_pass"},        32'(bus.pass),        32'd0);
        check_output({tag, "_score"},       32'(bus.score),       32'd0);
        check_output({tag, "_timed_out"},   32'(bus.timed_out),   32'd0);
    endtask

    task automatic pack_pattern();
        pat = '0;
        for (int i = 0; i < NUM_SYM; i++) pat[2*i +: 2] = sym[i];
        bus.pattern = pat;
    endtask

    task automatic random_pattern();
        for (int i = 0; i < NUM_SYM; i++) sym[i] = 2'($urandom_range(0, 2));
        pack_pattern();
    endtask

    task automatic random_presses();
        int err_pos;
        err_pos = ($urandom_range(0, 2) == 0) ? NUM_SYM : int'($urandom_range(0, NUM_SYM - 1));
        for (int i = 0; i < NUM_SYM; i++) begin
            if (i == err_pos) press[i] = 2'((int'(sym[i]) + 1 + int'($urandom_range(0, 2))) % 4);
            else              press[i] = sym[i];
        end
    endtask

    // Start a round, hold off the generator for wait_cycles, then watch the whole playback.
    task automatic play_phase(input int wait_cycles, input int abort_at);
        bus.pattern_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_output("start_busy",      32'(bus.busy),       32'd1);
        check_output("start_pass_clr",  32'(bus.pass),       32'd0);
        check_output("start_score_clr", 32'(bus.score),      32'd0);
        check_output("start_to_clr",    32'(bus.timed_out),  32'd0);
        check_output("start_show",      32'(bus.show_valid), 32'd0);
        repeat (wait_cycles) begin
            tick();
            check_output("wait_busy", 32'(bus.busy),       32'd1);
            check_output("wait_show", 32'(bus.show_valid), 32'd0);
        end
        bus.pattern_valid = 1'b1;
        tick();
        for (int t = 0; t < PLAY_LEN; t++) begin
            if (t == abort_at) begin
                bus.in_valid = 1'b0;
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                check_idle_zero("reset_mid_show");
                return;
            end
            check_output("play_show_valid", 32'(bus.show_valid), 32'((t % SYM_PERIOD) < SHOW_CYCLES));
            check_output("play_show_sym",   32'(bus.show_sym),   32'(sym[t / SYM_PERIOD]));
            check_output("play_show_idx",   32'(bus.show_idx),   32'(t / SYM_PERIOD));
            check_output("play_await",      32'(bus.await_input), 32'd0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sym   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.in_valid = 1'b0;
        check_output("input_await",     32'(bus.await_input), 32'd1);
        check_output("input_show",      32'(bus.show_valid),  32'd0);
        check_output("input_idx",       32'(bus.show_idx),    32'd0);
        check_output("input_score",     32'(bus.score),       32'd0);
        check_output("input_busy",      32'(bus.busy),        32'd1);
    endtask

    // Round outcome model: the first wrong press decides a fail, else the last press a pass.
    task automatic press_phase();
        int k, decide_at, exp_score;
        logic exp_pass;
        k = NUM_SYM;
        for (int i = 0; i < NUM_SYM; i++)
            if (k == NUM_SYM && (press[i] != sym[i] || press[i] == 2'd3)) k = i;
        exp_pass  = (k == NUM_SYM);
        exp_score = k;
        decide_at = exp_pass ? NUM_SYM - 1 : k;
        for (int p = 0; p <= decide_at; p++) begin
            repeat ($urandom_range(0, 2)) tick();
            bus.in_valid = 1'b1;
            bus.in_sym   = press[p];
            tick();
            bus.in_valid = 1'b0;
            if (p == decide_at) begin
                check_output("decide_done",  32'(bus.done),        32'd1);
                check_output("decide_pass",  32'(bus.pass),        32'(exp_pass));
                check_output("decide_score", 32'(bus.score),       32'(exp_score));
                check_output("decide_await", 32'(bus.await_input), 32'd0);
            end else begin
                check_output("press_done",  32'(bus.done),        32'd0);
                check_output("press_score", 32'(bus.score),       32'(p + 1));
                check_output("press_idx",   32'(bus.show_idx),    32'(p + 1));
                check_output("press_await", 32'(bus.await_input), 32'd1);
            end
        end
        tick();
        check_output("end_done",  32'(bus.done),  32'd0);
        check_output("end_busy",  32'(bus.busy),  32'd0);
        check_output("end_pass",  32'(bus.pass),  32'(exp_pass));
        check_output("end_score", 32'(bus.score), 32'(exp_score));
        bus.in_valid = 1'b1;
        bus.in_sym   = sym[0];
        tick();
        bus.in_valid = 1'b0;
        check_output("ignored_score", 32'(bus.score), 32'(exp_score));
        check_output("ignored_busy",  32'(bus.busy),  32'd0);
        check_output("ignored_pass",  32'(bus.pass),  32'(exp_pass));
    endtask

`ifdef TIMEOUT_EN
    task automatic timeout_round(input bit press_at_expiry);
        int exp_score;
        exp_score = 0;
        random_pattern();
        play_phase(0, -1);
        if (press_at_expiry) begin
            repeat (TIMEOUT_CYCLES - 1) begin
                tick();
                check_output("to_wait_done", 32'(bus.done), 32'd0);
            end
            bus.in_valid = 1'b1;
            bus.in_sym   = sym[0];
            tick();
            bus.in_valid = 1'b0;
            exp_score = 1;
            check_output("to_edge_done",  32'(bus.done),      32'd0);
            check_output("to_edge_flag",  32'(bus.timed_out), 32'd0);
            check_output("to_edge_score", 32'(bus.score),     32'd1);
        end
        repeat (TIMEOUT_CYCLES - 1) begin
            tick();
            check_output("to_idle_done", 32'(bus.done), 32'd0);
        end
        tick();
        check_output("to_done",  32'(bus.done),      32'd1);
        check_output("to_pass",  32'(bus.pass),      32'd0);
        check_output("to_flag",  32'(bus.timed_out), 32'd1);
        check_output("to_score", 32'(bus.score),     32'(exp_score));
        tick();
        check_output("to_hold_flag", 32'(bus.timed_out), 32'd1);
        check_output("to_hold_busy", 32'(bus.busy),      32'd0);
    endtask
`endif

    initial begin
        bus.start         = 1'b0;
        bus.pattern       = '0;
        bus.pattern_valid = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_sym        = '0;
        reset_n = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        reset_n = 1'b1;
        tick();
        check_idle_zero("idle");

        $display("[TB] round A: fixed pattern, all presses correct");
        pat = 18'h24924;
        for (int i = 0; i < NUM_SYM; i++) sym[i] = pat[2*i +: 2];
        bus.pattern = pat;
        for (int i = 0; i < NUM_SYM; i++) press[i] = sym[i];
        play_phase(0, -1);
        press_phase();

        $display("[TB] round B: fixed pattern, wrong third press");
        random_presses();
        press[0] = 2'd0;
        press[1] = 2'd1;
        press[2] = 2'd0;
        play_phase(0, -1);
        press_phase();

        $display("[TB] round C: generator late by 50 cycles");
        random_pattern();
        random_presses();
        play_phase(50, -1);
        press_phase();

        $display("[TB] reset during symbol 4 playback, then replay");
        random_pattern();
        play_phase(0, 4 * SYM_PERIOD + 1);
        random_presses();
        play_phase(0, -1);
        press_phase();

        $display("[TB] random rounds");
        repeat (8) begin
            random_pattern();
            random_presses();
            play_phase($urandom_range(0, 3), -1);
            press_phase();
        end

`ifdef TIMEOUT_EN
        $display("[TB] timeout rounds");
        timeout_round(1'b0);
        timeout_round(1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
